// File: rtl/video_fetch.sv
// Frame-memory reader: fetches bsize bytes over a single-outstanding read
// handshake, packs them little-endian and hands the word to the line buffer.
module video_fetch #(
    parameter int bsize       = 4,
    parameter int ADDR_W      = 17,
    parameter int FRAME_BYTES = 76800
) (
    input  logic                 clk25MHz,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 frame_start,
    input  logic                 watermark_on,
    input  logic                 full,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_rd,
    input  logic [7:0]           mem_data,
    input  logic                 mem_valid,
    output logic [bsize*8-1:0]   data,
    output logic                 load,
    output logic                 underrun
);

    localparam int WORD_W = bsize * 8;
    localparam int CNT_W  = (bsize > 1) ? $clog2(bsize) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(bsize - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HOLD, LOAD, DRAIN} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic                rd_reg, rd_next;
    logic [WORD_W-1:0]   data_reg, data_next;
    logic [WORD_W-1:0]   stage_reg, stage_next;
    logic                load_reg, load_next;
    logic                underrun_reg, underrun_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                pend_reg, pend_next;
    logic                prefetch_reg, prefetch_next;

    logic [WORD_W-1:0]   merged;
    logic [ADDR_W-1:0]   addr_inc;
    logic                drain_needed;

    // Staging word with the incoming byte dropped into the current slot.
    for (genvar gi = 0; gi < bsize; gi++) begin : g_slot
        assign merged[8*gi +: 8] = (cnt_reg == CNT_W'(gi)) ? mem_data : stage_reg[8*gi +: 8];
    end

    assign addr_inc = (addr_reg == LAST_ADDR) ? '0 : addr_reg + 1'b1;

    // A response that lands in the same cycle as frame_start retires the read.
    assign drain_needed = pend_reg &&
                          !(mem_valid && (state_reg == WAIT || state_reg == DRAIN));

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        rd_next       = 1'b0;
        data_next     = data_reg;
        stage_next    = stage_reg;
        load_next     = 1'b0;
        underrun_next = underrun_reg;
        cnt_next      = cnt_reg;
        pend_next     = pend_reg;
        prefetch_next = prefetch_reg;

        case (state_reg)
            IDLE: begin
                if (watermark_on || !full) begin
                    state_next    = ISSUE;
                    cnt_next      = '0;
                    prefetch_next = full;
                    rd_next       = 1'b1;
                    pend_next     = 1'b1;
                end
            end
            ISSUE: begin
                state_next = WAIT;
            end
            WAIT: begin
                if (mem_valid) begin
                    stage_next = merged;
                    pend_next  = 1'b0;
                    addr_next  = addr_inc;
                    if (cnt_reg == LAST_CNT) begin
                        state_next = HOLD;
                        data_next  = merged;
                    end else begin
                        cnt_next   = cnt_reg + 1'b1;
                        state_next = ISSUE;
                        rd_next    = 1'b1;
                        pend_next  = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (!full) begin
                    state_next = LOAD;
                    load_next  = 1'b1;
                end
            end
            LOAD: begin
                state_next = IDLE;
            end
            DRAIN: begin
                if (mem_valid) begin
                    pend_next  = 1'b0;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if ((state_reg == ISSUE || state_reg == WAIT) && prefetch_reg && !full) begin
            underrun_next = 1'b1;
        end

        if (frame_start) begin
            addr_next     = '0;
            cnt_next      = '0;
            underrun_next = 1'b0;
            load_next     = 1'b0;
            rd_next       = 1'b0;
            data_next     = data_reg;
            pend_next     = drain_needed;
            state_next    = drain_needed ? DRAIN : IDLE;
        end
    end

    always_ff @(posedge clk25MHz or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            addr_reg     <= '0;
            rd_reg       <= 1'b0;
            data_reg     <= '0;
            stage_reg    <= '0;
            load_reg     <= 1'b0;
            underrun_reg <= 1'b0;
            cnt_reg      <= '0;
            pend_reg     <= 1'b0;
            prefetch_reg <= 1'b0;
        end else if (en) begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            rd_reg       <= rd_next;
            data_reg     <= data_next;
            stage_reg    <= stage_next;
            load_reg     <= load_next;
            underrun_reg <= underrun_next;
            cnt_reg      <= cnt_next;
            pend_reg     <= pend_next;
            prefetch_reg <= prefetch_next;
        end
    end

    assign mem_addr = addr_reg;
    assign mem_rd   = rd_reg;
    assign data     = data_reg;
    assign load     = load_reg;
    assign underrun = underrun_reg;

endmodule

// File: tb/tb_video_fetch.sv
// Bench for video_fetch: a latency-programmable memory, a read/load monitor
// and a byte-stream model of which addresses and words each fetch must produce.
module tb_video_fetch;

    localparam int BSIZE  = 4;
    localparam int ADDR_W = 17;
    localparam int FB     = 6;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                en = 1'b1;
    logic                frame_start = 1'b0;
    logic                watermark_on = 1'b0;
    logic                full = 1'b1;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_rd;
    logic [7:0]          mem_data;
    logic                mem_valid;
    logic [BSIZE*8-1:0]  data;
    logic                load;
    logic                underrun;

    int checks = 0;
    int errors = 0;

    logic [7:0]        mem [0:FB-1];
    int                lat = 1;
    int                exp_ptr = 0;
    logic [ADDR_W-1:0] rd_q [$];
    logic [BSIZE*8-1:0] ld_q [$];
    int                pq_addr [$];
    int                pq_cnt [$];

    video_fetch #(.bsize(BSIZE), .ADDR_W(ADDR_W), .FRAME_BYTES(FB)) dut (
        .clk25MHz     (clk),
        .reset        (reset),
        .en           (en),
        .frame_start  (frame_start),
        .watermark_on (watermark_on),
        .full         (full),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .mem_valid    (mem_valid),
        .data         (data),
        .load         (load),
        .underrun     (underrun)
    );

    always #20 clk = ~clk;

    // Memory: answers each request after lat enabled cycles.
    initial begin
        logic rd_s, en_s;
        logic [ADDR_W-1:0] a_s;
        mem_valid = 1'b0;
        mem_data  = 8'h00;
        forever begin
            @(negedge clk);
            rd_s = mem_rd; a_s = mem_addr; en_s = en;
            @(posedge clk);
            #1;
            if (en_s) begin
                mem_valid = 1'b0;
                if (rd_s) begin
                    checks++;
                    if (pq_addr.size() != 0) begin
                        errors++;
                        $display("FAIL single_outstanding addr %0d pending %0d required 0", a_s, pq_addr.size());
                    end
                    pq_addr.push_back(int'(a_s));
                    pq_cnt.push_back(lat);
                end
                foreach (pq_cnt[i]) pq_cnt[i]--;
                if (pq_cnt.size() > 0 && pq_cnt[0] <= 0) begin
                    mem_valid = 1'b1;
                    mem_data  = mem[pq_addr[0]];
                    void'(pq_addr.pop_front());
                    void'(pq_cnt.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && en) begin
            if (mem_rd) rd_q.push_back(mem_addr);
            if (load)   ld_q.push_back(data);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [BSIZE*8-1:0] exp_word(input int p);
        logic [BSIZE*8-1:0] w;
        for (int k = 0; k < BSIZE; k++) w[8*k +: 8] = mem[(p + k) % FB];
        return w;
    endfunction

    function automatic logic [BSIZE*8-1:0] exp_addrs(input int p);
        logic [BSIZE*8-1:0] w;
        for (int k = 0; k < BSIZE; k++) w[8*k +: 8] = 8'((p + k) % FB);
        return w;
    endfunction

    function automatic logic [BSIZE*8-1:0] obs_addrs(input int b);
        logic [BSIZE*8-1:0] w;
        w = 'x;
        if (rd_q.size() >= b + BSIZE)
            for (int k = 0; k < BSIZE; k++) w[8*k +: 8] = rd_q[b + k][7:0];
        return w;
    endfunction

    task automatic fill_mem(input int r);
        for (int i = 0; i < FB; i++) mem[i] = 8'(r + i * 37);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_load(input int budget, input logic full_after, output bit got, output int cyc);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (load) got = 1'b1;
        end
        if (got) begin
            @(posedge clk);
            #1;
            full = full_after;
        end
    endtask

    task automatic wait_reads(input int target);
        int n = 0;
        while (rd_q.size() < target && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; frame_start = 1'b0; watermark_on = 1'b0; full = 1'b1;
        tick(3);
        @(negedge clk);
        checks++;
        if (mem_addr !== '0) begin errors++; $display("FAIL reset_addr got %0h want 0", mem_addr); end
        checks++;
        if ({mem_rd, load, underrun} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got rd%b ld%b ur%b want 000", mem_rd, load, underrun);
        end
        checks++;
        if (data !== '0) begin errors++; $display("FAIL reset_data got %h want 0", data); end
    endtask

    task automatic test_reset_fill();
        bit got; int cyc, b;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44; mem[4] = 8'h55; mem[5] = 8'h66;
        lat = 1; full = 1'b0; watermark_on = 1'b0;
        @(posedge clk); #1;
        b = rd_q.size();
        reset = 1'b0;
        wait_load(60, 1'b1, got, cyc);
        checks++;
        if (!got) begin errors++; $display("FAIL fill_timeout no load within 60 cycles"); end
        checks++;
        if (cyc != 2 * BSIZE + 3) begin errors++; $display("FAIL fill_latency got %0d want %0d", cyc, 2 * BSIZE + 3); end
        checks++;
        if (obs_addrs(b) !== exp_addrs(0)) begin errors++; $display("FAIL fill_addrs got %h want %h", obs_addrs(b), exp_addrs(0)); end
        checks++;
        if (data !== 32'h44332211) begin errors++; $display("FAIL fill_data got %h want 44332211", data); end
        @(negedge clk);
        checks++;
        if (load !== 1'b0) begin errors++; $display("FAIL fill_load_width got %b want 0", load); end
        checks++;
        if (mem_addr !== ADDR_W'(4)) begin errors++; $display("FAIL fill_addr_end got %0d want 4", mem_addr); end
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL fill_underrun got %b want 0", underrun); end
        exp_ptr = 4;
        $display("fill: addrs %h data %h latency %0d", obs_addrs(b), data, cyc);
    endtask

    task automatic test_prefetch_hold();
        int b, nl;
        @(posedge clk); #1;
        b = rd_q.size(); nl = ld_q.size();
        tick(4);
        @(negedge clk);
        checks++;
        if (rd_q.size() != b) begin errors++; $display("FAIL idle_no_read got %0d reads want 0", rd_q.size() - b); end
        fill_mem($urandom);
        lat = $urandom_range(1, 3);
        @(posedge clk); #1;
        watermark_on = 1'b1;
        wait_reads(b + BSIZE);
        tick(lat + 3);
        @(negedge clk);
        checks++;
        if (load !== 1'b0 || ld_q.size() != nl) begin errors++; $display("FAIL hold_no_load got %0d loads want 0", ld_q.size() - nl); end
        checks++;
        if (data !== exp_word(exp_ptr)) begin errors++; $display("FAIL hold_data got %h want %h", data, exp_word(exp_ptr)); end
        @(posedge clk); #1;
        full = 1'b0; watermark_on = 1'b0;
        @(negedge clk);
        checks++;
        if (load !== 1'b0) begin errors++; $display("FAIL hold_load_early got %b want 0", load); end
        @(negedge clk);
        checks++;
        if (load !== 1'b1) begin errors++; $display("FAIL hold_load_edge got %b want 1", load); end
        @(posedge clk); #1;
        full = 1'b1;
        @(negedge clk);
        checks++;
        if (obs_addrs(b) !== exp_addrs(exp_ptr)) begin errors++; $display("FAIL hold_addrs got %h want %h", obs_addrs(b), exp_addrs(exp_ptr)); end
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL hold_underrun got %b want 0", underrun); end
        $display("prefetch: lat %0d addrs %h data %h", lat, obs_addrs(b), data);
        exp_ptr = (exp_ptr + BSIZE) % FB;
    endtask

    task automatic test_back_to_back();
        bit got; int cyc, b;
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_addr !== '0) begin errors++; $display("FAIL fs_addr got %0d want 0", mem_addr); end
        exp_ptr = 0;
        fill_mem($urandom);
        lat = $urandom_range(1, 4);
        @(posedge clk); #1;
        b = rd_q.size();
        full = 1'b0;
        for (int f = 0; f < 2; f++) begin
            wait_load(100, (f == 1) ? 1'b1 : 1'b0, got, cyc);
            checks++;
            if (!got || data !== exp_word(exp_ptr)) begin
                errors++; $display("FAIL b2b_data%0d got %h want %h", f, data, exp_word(exp_ptr));
            end
            checks++;
            if (obs_addrs(b + f * BSIZE) !== exp_addrs(exp_ptr)) begin
                errors++; $display("FAIL b2b_addrs%0d got %h want %h", f, obs_addrs(b + f * BSIZE), exp_addrs(exp_ptr));
            end
            $display("b2b: fetch %0d lat %0d addrs %h data %h", f, lat, obs_addrs(b + f * BSIZE), data);
            exp_ptr = (exp_ptr + BSIZE) % FB;
        end
        @(negedge clk);
        checks++;
        if (mem_addr !== ADDR_W'(exp_ptr)) begin errors++; $display("FAIL b2b_wrap_addr got %0d want %0d", mem_addr, exp_ptr); end
    endtask

    task automatic test_abort();
        bit got; int cyc, b, b2, nl;
        for (int l = 3; l <= 4; l++) begin
            fill_mem($urandom);
            lat = l;
            @(posedge clk); #1;
            b = rd_q.size(); nl = ld_q.size();
            full = 1'b0; watermark_on = 1'b0;
            wait_reads(b + 3);
            @(posedge clk); #1;
            frame_start = 1'b1;
            tick(1);
            frame_start = 1'b0;
            @(negedge clk);
            checks++;
            if (mem_addr !== '0 || mem_rd !== 1'b0 || load !== 1'b0) begin
                errors++; $display("FAIL abort_outputs got addr %0d rd %b ld %b want 0 0 0", mem_addr, mem_rd, load);
            end
            b2 = rd_q.size();
            exp_ptr = 0;
            wait_load(100, 1'b1, got, cyc);
            checks++;
            if (!got || ld_q.size() != nl + 1) begin
                errors++; $display("FAIL abort_loads got %0d want 1", ld_q.size() - nl);
            end
            checks++;
            if (data !== exp_word(0)) begin errors++; $display("FAIL abort_data got %h want %h", data, exp_word(0)); end
            checks++;
            if (obs_addrs(b2) !== exp_addrs(0)) begin errors++; $display("FAIL abort_addrs got %h want %h", obs_addrs(b2), exp_addrs(0)); end
            $display("abort: lat %0d refetch addrs %h data %h", lat, obs_addrs(b2), data);
            exp_ptr = BSIZE % FB;
        end
    endtask

    task automatic test_underrun_enable();
        bit got; int cyc, b, n;
        logic [ADDR_W-1:0] a_exp;
        fill_mem($urandom);
        lat = $urandom_range(1, 3);
        @(posedge clk); #1;
        b = rd_q.size();
        full = 1'b1; watermark_on = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mem_valid !== 1'b1 && n < 100);
        @(posedge clk); #1;
        en = 1'b0;
        a_exp = ADDR_W'((exp_ptr + 1) % FB);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (mem_rd !== 1'b1 || mem_addr !== a_exp) begin
                errors++; $display("FAIL freeze%0d got rd %b addr %0d want 1 %0d", i, mem_rd, mem_addr, a_exp);
            end
            @(posedge clk); #1;
        end
        en = 1'b1; full = 1'b0; watermark_on = 1'b0;
        wait_load(100, 1'b1, got, cyc);
        checks++;
        if (!got || data !== exp_word(exp_ptr)) begin errors++; $display("FAIL resume_data got %h want %h", data, exp_word(exp_ptr)); end
        checks++;
        if (obs_addrs(b) !== exp_addrs(exp_ptr) || rd_q.size() != b + BSIZE) begin
            errors++; $display("FAIL resume_addrs got %h (%0d reads) want %h", obs_addrs(b), rd_q.size() - b, exp_addrs(exp_ptr));
        end
        tick(3);
        @(negedge clk);
        checks++;
        if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_sticky got %b want 1", underrun); end
        $display("underrun: lat %0d addrs %h data %h underrun %b", lat, obs_addrs(b), data, underrun);
        @(posedge clk); #1;
        frame_start = 1'b1;
        tick(1);
        frame_start = 1'b0;
        @(negedge clk);
        checks++;
        if (underrun !== 1'b0) begin errors++; $display("FAIL underrun_clear got %b want 0", underrun); end
        exp_ptr = 0;
    endtask

    task automatic test_async_reset();
        bit got; int cyc, b, b2, nl;
        fill_mem($urandom);
        lat = 3;
        @(posedge clk); #1;
        b = rd_q.size();
        full = 1'b0; watermark_on = 1'b0;
        wait_reads(b + 2);
        @(negedge clk);
        #5;
        reset = 1'b1;
        #1;
        checks++;
        if (mem_addr !== '0 || {mem_rd, load, underrun} !== 3'b000 || data !== '0) begin
            errors++; $display("FAIL async_reset got addr %0d rd %b ld %b ur %b data %h want all 0", mem_addr, mem_rd, load, underrun, data);
        end
        full = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        b2 = rd_q.size(); nl = ld_q.size();
        tick(12);
        @(negedge clk);
        checks++;
        if (rd_q.size() != b2 || ld_q.size() != nl || load !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle got %0d reads %0d loads want 0 0", rd_q.size() - b2, ld_q.size() - nl);
        end
        exp_ptr = 0;
        @(posedge clk); #1;
        full = 1'b0;
        wait_load(100, 1'b1, got, cyc);
        checks++;
        if (!got || data !== exp_word(0)) begin errors++; $display("FAIL post_reset_data got %h want %h", data, exp_word(0)); end
        checks++;
        if (obs_addrs(b2) !== exp_addrs(0)) begin errors++; $display("FAIL post_reset_addrs got %h want %h", obs_addrs(b2), exp_addrs(0)); end
        $display("async reset: refetch addrs %h data %h", obs_addrs(b2), data);
        exp_ptr = BSIZE % FB;
    endtask

    task automatic test_random();
        bit got; int cyc, b, mode;
        for (int it = 0; it < 6; it++) begin
            fill_mem($urandom);
            lat = $urandom_range(1, 4);
            mode = $urandom_range(0, 1);
            @(posedge clk); #1;
            b = rd_q.size();
            if (mode == 0) begin
                full = 1'b0; watermark_on = 1'b0;
            end else begin
                full = 1'b1; watermark_on = 1'b1;
                wait_reads(b + BSIZE);
                tick(lat + $urandom_range(1, 4));
                full = 1'b0; watermark_on = 1'b0;
            end
            wait_load(100, 1'b1, got, cyc);
            checks++;
            if (!got || data !== exp_word(exp_ptr)) begin errors++; $display("FAIL rand%0d_data got %h want %h", it, data, exp_word(exp_ptr)); end
            checks++;
            if (obs_addrs(b) !== exp_addrs(exp_ptr)) begin errors++; $display("FAIL rand%0d_addrs got %h want %h", it, obs_addrs(b), exp_addrs(exp_ptr)); end
            checks++;
            if (underrun !== 1'b0) begin errors++; $display("FAIL rand%0d_underrun got %b want 0", it, underrun); end
            $display("random %0d: mode %0d lat %0d addrs %h data %h", it, mode, lat, obs_addrs(b), data);
            exp_ptr = (exp_ptr + BSIZE) % FB;
        end
    endtask

    initial begin
        test_reset();
        test_reset_fill();
        test_prefetch_hold();
        test_back_to_back();
        test_abort();
        test_underrun_enable();
        test_async_reset();
        test_random();
        tick(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
